// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: state encodings,
// default register-address width and the packed control-output bundle.
package pipe_ctrl_defs;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LU  = 2'd1,
        ST_MW  = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } ctrl_t;

    // Field order matches ctrl_t: pcw, ifw, iff, idw, idf, exw, mwf.
    localparam ctrl_t CTRL_DEF = ctrl_t'(7'b1101010);
    localparam ctrl_t CTRL_RST = ctrl_t'(7'b0010101);
    localparam ctrl_t CTRL_FRZ = ctrl_t'(7'b0000001);
    localparam ctrl_t CTRL_LU  = ctrl_t'(7'b0001110);
    localparam ctrl_t CTRL_BR  = ctrl_t'(7'b1111110);

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and data-memory
// wait freezes with timeout, plus saturating stall/flush statistics.
module hazard_stall_controller #(
    parameter int REG_AW  = pipe_ctrl_defs::REG_AW,
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              id_uses_rt,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              err_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic              mem_wb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_tmo_err,
    output logic [1:0]        dbg_state
);
    import pipe_ctrl_defs::*;

    localparam int TMR_W = $clog2(MEM_TMO + 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             mem_stall, lu_hazard, tmo_hit;
    ctrl_t            ctrl;

    assign mem_stall = mem_req & ~mem_ready;
    // Register 0 is s0 in this core, so no zero-register exclusion.
    assign lu_hazard = id_ex_memread &
                       ((if_id_rs == id_ex_rt) | (id_uses_rt & (if_id_rt == id_ex_rt)));
    assign tmo_hit   = (state_q == ST_MW) && !mem_ready && (tmr_q == TMR_W'(MEM_TMO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        err_d   = tmo_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
        case (state_q)
            ST_MW: begin
                if (mem_ready || tmo_hit) state_d = ST_RUN;
                else                      tmr_d   = tmr_q + TMR_W'(1);
            end
            ST_LU: begin
                if (mem_stall) begin
                    state_d = ST_MW;
                    tmr_d   = TMR_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (mem_stall) begin
                    state_d = ST_MW;
                    tmr_d   = TMR_W'(1);
                end else if (!ex_br_taken && lu_hazard) begin
                    state_d = ST_LU;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        ctrl = CTRL_DEF;
        if (!rst_n) begin
            ctrl = CTRL_RST;
        end else begin
            case (state_q)
                ST_MW: if (!mem_ready && !tmo_hit) ctrl = CTRL_FRZ;
                ST_LU: if (mem_stall) ctrl = CTRL_FRZ;
                default: begin
                    if (mem_stall)        ctrl = CTRL_FRZ;
                    else if (ex_br_taken) ctrl = CTRL_BR;
                    else if (lu_hazard)   ctrl = CTRL_LU;
                end
            endcase
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_write  = ctrl.id_ex_write;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_tmo_err  = err_q;
    assign dbg_state    = state_q;

    // A freeze always drops pc_write, so the freeze term is implied by !pc_write.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rst_n & ~ctrl.pc_write),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rst_n & ctrl.if_id_flush),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (CNT_W=4, MEM_TMO=4) with
// hand-computed expectations checked by immediate assertions.
module tb_hazard_stall_controller;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    // Control vector order: pcw, ifw, iff, idw, idf, exw, mwf
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] if_id_rs, if_id_rt, id_ex_rt;
    logic              id_uses_rt, id_ex_memread, ex_br_taken;
    logic              mem_req, mem_ready, err_clr;
    logic              pc_write, if_id_write, if_id_flush, id_ex_write;
    logic              id_ex_flush, ex_mem_write, mem_wb_flush, mem_tmo_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    hazard_stall_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TMO(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_tmo_err(mem_tmo_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_vec();
        return 32'({pc_write, if_id_write, if_id_flush, id_ex_write,
                    id_ex_flush, ex_mem_write, mem_wb_flush});
    endfunction

    // Combinational outputs are checked at the falling edge; registered ones 1ns after rising.
    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check(tag, ctrl_vec(), 32'(exp));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
        id_uses_rt = 1'b0; id_ex_memread = 1'b0; ex_br_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // 1. reset for two cycles
        chk_ctrl("rst_ctrl_c0", C_RST);
        adv();
        chk_ctrl("rst_ctrl_c1", C_RST);
        adv();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst_err", 32'(mem_tmo_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        chk_ctrl("post_rst_default", C_DEF);
        adv();

        // 2. load-use on rs, then on rt with register 0, then rt not used
        id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        chk_ctrl("lu_rs_stall", C_LU);
        adv();
        check("lu_rs_state", 32'(dbg_state), 32'd1);
        chk_ctrl("lu_rs_release", C_DEF);
        adv();
        check("lu_rs_state_run", 32'(dbg_state), 32'd0);
        check("lu_rs_stall_cnt", 32'(stall_cnt), 32'd1);
        id_ex_rt = 5'd0; if_id_rs = 5'd3; if_id_rt = 5'd0; id_uses_rt = 1'b1;
        chk_ctrl("lu_r0_stall", C_LU);
        adv();
        chk_ctrl("lu_r0_release", C_DEF);
        adv();
        check("lu_r0_stall_cnt", 32'(stall_cnt), 32'd2);
        id_uses_rt = 1'b0;
        chk_ctrl("lu_rt_unused", C_DEF);
        adv();
        check("lu_rt_unused_cnt", 32'(stall_cnt), 32'd2);
        check("lu_rt_unused_state", 32'(dbg_state), 32'd0);

        // 3. branch beats a coincident load-use
        do_reset();
        id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; ex_br_taken = 1'b1;
        chk_ctrl("br_lu_ctrl", C_BR);
        adv();
        check("br_lu_state", 32'(dbg_state), 32'd0);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // 4. memory wait of three cycles, released in the ready cycle
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctrl($sformatf("mw_freeze_%0d", i), C_FRZ);
            adv();
            check($sformatf("mw_state_%0d", i), 32'(dbg_state), 32'd2);
        end
        mem_ready = 1'b1;
        chk_ctrl("mw_release", C_DEF);
        adv();
        check("mw_state_run", 32'(dbg_state), 32'd0);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw_no_err", 32'(mem_tmo_err), 32'd0);

        // 5. timeout after four freeze cycles, sticky error, clear, set-dominance
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_ctrl($sformatf("tmo_freeze_%0d", i), C_FRZ);
            adv();
        end
        check("tmo_err_pending", 32'(mem_tmo_err), 32'd0);
        chk_ctrl("tmo_release", C_DEF);
        adv();
        check("tmo_err_set", 32'(mem_tmo_err), 32'd1);
        check("tmo_state_run", 32'(dbg_state), 32'd0);
        check("tmo_stall_cnt", 32'(stall_cnt), 32'd4);
        mem_req = 1'b0;
        adv();
        check("tmo_err_sticky", 32'(mem_tmo_err), 32'd1);
        err_clr = 1'b1;
        adv();
        check("tmo_err_cleared", 32'(mem_tmo_err), 32'd0);
        mem_req = 1'b1;
        repeat (5) adv();
        check("tmo_set_dominant", 32'(mem_tmo_err), 32'd1);
        mem_req = 1'b0;
        adv();
        check("tmo_clr_after", 32'(mem_tmo_err), 32'd0);
        err_clr = 1'b0;

        // 6. twenty back-to-back load-use stalls saturate the 4-bit counter
        do_reset();
        id_ex_memread = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
        repeat (28) adv();
        check("sat_stall_14", 32'(stall_cnt), 32'd14);
        repeat (12) adv();
        check("sat_stall_15", 32'(stall_cnt), 32'd15);
        check("sat_flush_0", 32'(flush_cnt), 32'd0);
        id_ex_memread = 1'b0;
        mem_req = 1'b1;
        repeat (2) adv();
        check("rst_mw_state_pre", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        chk_ctrl("rst_mw_ctrl", C_RST);
        adv();
        check("rst_mw_state", 32'(dbg_state), 32'd0);
        check("rst_mw_err", 32'(mem_tmo_err), 32'd0);
        check("rst_mw_stall_cnt", 32'(stall_cnt), 32'd0);
        mem_req = 1'b0;
        rst_n = 1'b1;
        repeat (4) adv();
        check("rst_mw_err_later", 32'(mem_tmo_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
